inst_line_buffer: RTL and testbench
===================================

# inst_line_buffer

Single-line instruction fetch buffer between the OpenMIPS core's instruction port (`rom_ce`/`rom_addr`/`rom_data`) and a multi-cycle instruction memory with a req/ack handshake. It holds one line of `LINE_WORDS` instructions and serves hits combinationally in the same cycle. On a miss it raises `stall_o` and refills the line one word at a time. It sits directly upstream of the core's IF stage and replaces a zero-wait ROM.

## Interface
Parameters:
- `LINE_WORDS`, default 4: words per line; a power of 2 in the range 2..16. `OFF = log2(LINE_WORDS)+2`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-low (`rst==0` at a rising edge resets).
- `rom_ce_i`  in  1  core fetch enable.
- `rom_addr_i`  in  32  core byte address; bits [1:0] are ignored.
- `rom_data_o`  out  32  instruction to the core.
- `stall_o`  out  1  core must hold the PC and IF/ID registers.
- `flush_i`  in  1  invalidate the line.
- `mem_req_o`  out  1  memory request, registered.
- `mem_addr_o`  out  32  word-aligned memory address, registered.
- `mem_ack_i`  in  1  memory accepts the request; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  32  memory read data.
- `stall_cnt_o`  out  32  stall-cycle counter (see Configuration).

## Operation
- State: `valid`, `tag[31:OFF]`, `data[0..LINE_WORDS-1]`, FSM {IDLE, FILL}, word counter `k`, latched line base `base`.
- Hit means `rom_ce_i` && `valid` && `tag==rom_addr_i[31:OFF]`.
  - `rom_data_o = data[rom_addr_i[OFF-1:2]]`.
  - `stall_o = 0`.
- `rom_ce_i==0`: `rom_data_o = 0`, `stall_o = 0`, no fill is started.
- Miss means `rom_ce_i` && !hit. `stall_o = 1` combinationally and `rom_data_o = 0`.
- Miss in IDLE, at the edge:
  - FSM goes to FILL.
  - `valid` is cleared.
  - `base` is latched from `{rom_addr_i[31:OFF], OFF'b0}`.
  - `k` is set to 0.
  - `mem_req_o` is set to 1 and `mem_addr_o` to `base`.
- In FILL, `stall_o = 1` unconditionally.
- On each edge in FILL where `mem_req_o && mem_ack_i`:
  - `data[k]` captures `mem_rdata_i`.
  - If `k < LINE_WORDS-1`: `k` increments, `mem_addr_o` becomes `base + 4*(k+1)`, and `mem_req_o` stays 1.
  - If `k == LINE_WORDS-1`: `mem_req_o` drops to 0, `tag` is set from `base`, `valid` is set to 1 (unless flush is pending), and the FSM returns to IDLE.
- `mem_ack_i` while `mem_req_o==0` is ignored.
- `mem_addr_o` and `mem_req_o` are stable while waiting for ack.
- Address change during FILL: the fill completes for the latched `base`. Hit/miss is re-evaluated in IDLE; a different line then causes a new miss.
- `flush_i` in IDLE clears `valid` at the edge; a hit in that same cycle is still served.
- `flush_i` in FILL sets a `flush_pend` flag. The fill runs to completion on the bus, then `valid` stays 0 and `flush_pend` clears.
- Flush and miss in the same IDLE cycle: the miss wins and the fill starts; `valid` is already being cleared by the fill.

## Timing
- Reset values:
  - `valid=0`, FSM=IDLE, `k=0`, `flush_pend=0`.
  - `mem_req_o=0`, `mem_addr_o=0`, `stall_cnt_o=0`.
  - `rom_data_o` and `stall_o` follow the combinational rules above (a miss right after reset if `rom_ce_i=1`).
- Reset mid-FILL: the request is abandoned at that edge (`mem_req_o=0` next cycle) and the line stays invalid. Memory must tolerate a dropped request.
- Hit latency: 0 cycles (combinational).
- Miss penalty with zero-wait memory (ack every cycle the request is up):
  - Miss detected in cycle t.
  - `mem_req_o` is high in cycles t+1 .. t+LINE_WORDS.
  - Hit in cycle t+LINE_WORDS+1.
  - Total `stall_o` cycles = LINE_WORDS+1.
- Each cycle without ack while the request is up adds one stall cycle.
- Back-to-back misses to different lines: one IDLE cycle between fills, which is where the miss is detected.

## Configuration
- `STALL_CNT_EN` defined:
  - `stall_cnt_o` increments by 1 at each edge where `stall_o==1`.
  - It wraps from 0xFFFFFFFF to 0.
  - It resets to 0 and is not cleared by `flush_i`.
- `STALL_CNT_EN` undefined: `stall_cnt_o` is tied to 0 and no counter register is synthesised.

## Test plan
- Reset then cold fetch at 0x0000_0000 with `rom_ce_i=1` and ack always high, memory returning data = address:
  - `stall_o` is high for 5 cycles.
  - Requests go out at 0x0, 0x4, 0x8, 0xC.
  - In the next cycle `rom_data_o=0x0000_0000`; addresses 0x4, 0x8, 0xC then hit with 0 stall.
- Wait states: ack only every third requested cycle during the fill of line 0x0000_0100:
  - `mem_addr_o` holds each word address until its ack.
  - Stall lasts 1+3*4=13 cycles.
  - The data lands in the correct slots.
- Line switch: after line 0x0 is filled, fetch 0x10 → new fill at 0x10..0x1C. A later fetch of 0x0 misses again, since only one line is held.
- `flush_i` pulsed during the second word of a fill:
  - The fill completes with 4 acks.
  - The same address then misses again, restarting at word 0.
- Reset asserted (`rst=0`) on the edge of the 3rd ack of a fill:
  - `mem_req_o=0` next cycle.
  - After release, the same fetch restarts the fill at `base` with no false hit.
- With `STALL_CNT_EN` defined, preload the counter to 0xFFFF_FFFE via forced cold misses or a force, then run 3 stall cycles → `stall_cnt_o=0x0000_0001`. Without the macro, `stall_cnt_o` stays 0 throughout.

Source files
------------

// File: rtl/inst_line_buffer.sv
// inst_line_buffer: single-line instruction fetch buffer.
// Sits between the OpenMIPS core's instruction port and a multi-cycle
// instruction memory that uses a req/ack handshake. It serves hits
// combinationally, and on a miss it stalls the core while it refills the
// whole line one word at a time.
// Optional feature: define STALL_CNT_EN to build the 32-bit stall-cycle
// counter on stall_cnt_o. Otherwise stall_cnt_o is tied to zero.
module inst_line_buffer #(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        stall_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] stall_cnt_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF   = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(LINE_WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state;
    logic              valid;
    logic              flush_pend;
    logic [31:OFF]     tag;
    logic [31:0]       data [LINE_WORDS];
    logic [IDX_W-1:0]  k;
    logic [31:0]       base;

    logic              hit;
    logic              miss;
    logic              fill_beat;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  k_inc;
    logic [31:0]       next_addr;
    logic [31:0]       miss_base;
    logic              unused_addr_bits;

    // Byte-offset bits of the fetch address carry no information for word fetches.
    assign unused_addr_bits = ^rom_addr_i[1:0];

    assign rd_idx    = rom_addr_i[OFF-1:2];
    assign hit       = rom_ce_i && valid && (tag == rom_addr_i[31:OFF]);
    assign miss      = rom_ce_i && !hit;
    assign stall_o   = (state == FILL) || miss;
    assign rom_data_o = hit ? data[rd_idx] : '0;

    // An accepted beat only ever happens while filling with the request up.
    assign fill_beat = (state == FILL) && mem_req_o && mem_ack_i;
    assign k_inc     = k + 1'b1;
    assign next_addr = base + (32'(k_inc) << 2);
    assign miss_base = {rom_addr_i[31:OFF], {OFF{1'b0}}};

    // Line storage: capture each returned word into its slot.
    // NOTE: the data array has no reset; valid gates every read, so its contents never need a known value.
    always_ff @(posedge clk) begin
        if (rst && fill_beat) begin
            data[k] <= mem_rdata_i;
        end
    end

    // Refill controller: miss detection in IDLE, word-by-word fetch in FILL.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= 1'b0;
            flush_pend <= 1'b0;
            k          <= '0;
            base       <= '0;
            tag        <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        // A miss takes priority over a flush; the line is invalidated anyway.
                        state      <= FILL;
                        valid      <= 1'b0;
                        flush_pend <= 1'b0;
                        k          <= '0;
                        base       <= miss_base;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= miss_base;
                    end else if (flush_i) begin
                        valid <= 1'b0;
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_req_o && mem_ack_i) begin
                        if (k != LAST_WORD) begin
                            k          <= k_inc;
                            mem_addr_o <= next_addr;
                        end else begin
                            // Last word in: the line becomes usable unless a flush arrived meanwhile.
                            mem_req_o  <= 1'b0;
                            tag        <= base[31:OFF];
                            valid      <= !(flush_pend || flush_i);
                            flush_pend <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Count every edge at which the core is held; wraps naturally and ignores flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_o) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_line_buffer.sv
// Directed testbench for inst_line_buffer (LINE_WORDS = 4).
// The memory model returns data equal to the requested address. Expected bus
// addresses and expected fetch data are queued when a fetch is issued and
// popped when the DUT accepts a beat or releases the stall.
module tb_inst_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        stall_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] stall_cnt_o;

    logic        wait_mode = 1'b0;
    logic        stray_ack = 1'b0;
    int          req_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_a [$];
    logic [31:0] exp_d [$];
    logic        hold_pending = 1'b0;
    logic [31:0] held_addr = '0;
    logic [31:0] stall_edges = '0;
    logic        preload_on = 1'b0;
    logic [31:0] preload = '0;
    logic [31:0] mark = '0;

    inst_line_buffer #(.LINE_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .stall_o     (stall_o),
        .flush_i     (flush_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Memory model: data = address; in wait mode ack on every third requested cycle.
    assign mem_rdata_i = mem_addr_o;
    assign mem_ack_i   = stray_ack || (mem_req_o && (!wait_mode || req_cnt == 2));

    always @(posedge clk) begin
        if (!rst)                       req_cnt <= 0;
        else if (mem_req_o && mem_ack_i) req_cnt <= 0;
        else if (mem_req_o)              req_cnt <= req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef STALL_CNT_EN
        return preload_on ? preload + (stall_edges - mark) : stall_edges;
`else
        return 32'd0;
`endif
    endfunction

    task automatic expect_fill(input logic [31:0] line_base);
        for (int i = 0; i < 4; i++) exp_a.push_back(line_base + 32'(4 * i));
    endtask

    // Mid-cycle sample: track stall edges and check every bus beat.
    task automatic sample();
        logic [31:0] e;
        @(negedge clk);
        if (!rst)         stall_edges = '0;
        else if (stall_o) stall_edges = stall_edges + 32'd1;
        if (mem_req_o) begin
            if (hold_pending) check("addr hold", mem_addr_o, held_addr);
            if (mem_ack_i) begin
                e = 'x;
                if (exp_a.size() > 0) e = exp_a.pop_front();
                check("bus addr", mem_addr_o, e);
                hold_pending = 1'b0;
            end else begin
                hold_pending = 1'b1;
                held_addr    = mem_addr_o;
            end
        end else begin
            hold_pending = 1'b0;
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Fetch one address, wait (bounded) for the stall to clear, check data and stall length.
    task automatic fetch(input logic [31:0] addr, input int exp_stall, input string tag);
        int          stalls;
        logic [31:0] e;
        stalls     = 0;
        rom_ce_i   = 1'b1;
        rom_addr_i = addr;
        exp_d.push_back({addr[31:2], 2'b00});
        sample();
        while (stall_o === 1'b1 && stalls < 200) begin
            stalls++;
            edge_step();
            sample();
        end
        e = exp_d.pop_front();
        check({tag, " data"}, rom_data_o, e);
        check({tag, " stalls"}, 32'(stalls), 32'(exp_stall));
        check({tag, " cnt"}, stall_cnt_o, exp_cnt());
        edge_step();
    endtask

    initial begin
        rst        = 1'b0;
        rom_ce_i   = 1'b0;
        rom_addr_i = '0;
        flush_i    = 1'b0;

        // Reset values
        edge_step();
        sample();
        check("rst stall", {31'd0, stall_o}, 32'd0);
        check("rst data", rom_data_o, 32'd0);
        check("rst req", {31'd0, mem_req_o}, 32'd0);
        check("rst addr", mem_addr_o, 32'd0);
        check("rst cnt", stall_cnt_o, 32'd0);
        edge_step();
        rom_ce_i = 1'b1;
        sample();
        check("rst miss stall", {31'd0, stall_o}, 32'd1);
        check("rst miss data", rom_data_o, 32'd0);
        edge_step();
        rst = 1'b1;

        // Cold fetch with zero-wait memory
        expect_fill(32'h0);
        fetch(32'h0, 5, "cold");
        fetch(32'h4, 0, "hit4");
        fetch(32'h8, 0, "hit8");
        fetch(32'hF, 0, "hitC");
        rom_ce_i = 1'b0;
        sample();
        check("idle req", {31'd0, mem_req_o}, 32'd0);
        check("ce0 data", rom_data_o, 32'd0);
        check("ce0 stall", {31'd0, stall_o}, 32'd0);
        edge_step();

        // Line switch and re-miss on the old line
        expect_fill(32'h10);
        fetch(32'h10, 5, "sw10");
        fetch(32'h1C, 0, "hit1C");
        expect_fill(32'h0);
        fetch(32'h8, 5, "remiss0");

        // Wait states on line 0x100
        wait_mode = 1'b1;
        expect_fill(32'h100);
        fetch(32'h104, 13, "wait");
        wait_mode = 1'b0;
        fetch(32'h100, 0, "w100");
        fetch(32'h108, 0, "w108");
        fetch(32'h10C, 0, "w10C");

        // Stray ack while idle is ignored
        rom_ce_i  = 1'b0;
        stray_ack = 1'b1;
        sample(); edge_step();
        sample(); edge_step();
        stray_ack = 1'b0;
        fetch(32'h108, 0, "stray");

        // Flush during the second word of a fill
        expect_fill(32'h200);
        expect_fill(32'h200);
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h200;
        sample(); edge_step();
        sample(); edge_step();
        flush_i = 1'b1;
        sample(); edge_step();
        flush_i = 1'b0;
        fetch(32'h200, 7, "flushfill");

        // Flush in IDLE: hit still served that cycle, then a miss
        rom_addr_i = 32'h204;
        flush_i    = 1'b1;
        sample();
        check("flush idle data", rom_data_o, 32'h204);
        check("flush idle stall", {31'd0, stall_o}, 32'd0);
        edge_step();
        flush_i = 1'b0;
        expect_fill(32'h200);
        fetch(32'h204, 5, "postflush");

        // Reset on the edge of the 3rd ack
        exp_a.push_back(32'h300);
        exp_a.push_back(32'h304);
        exp_a.push_back(32'h308);
        rom_addr_i = 32'h304;
        sample(); edge_step();
        sample(); edge_step();
        sample(); edge_step();
        rst = 1'b0;
        sample(); edge_step();
        sample();
        check("rst fill req", {31'd0, mem_req_o}, 32'd0);
        edge_step();
        rst = 1'b1;
        expect_fill(32'h300);
        fetch(32'h308, 5, "refill");

        // Stall counter wrap
        rom_ce_i = 1'b0;
        sample(); edge_step();
`ifdef STALL_CNT_EN
        force dut.stall_cnt = 32'hFFFF_FFFC;
        preload    = 32'hFFFF_FFFC;
        mark       = stall_edges;
        preload_on = 1'b1;
        #1;
        release dut.stall_cnt;
`endif
        sample(); edge_step();
        expect_fill(32'h400);
        fetch(32'h404, 5, "cntwrap");
`ifdef STALL_CNT_EN
        check("cnt final", stall_cnt_o, 32'h1);
`else
        check("cnt final", stall_cnt_o, 32'h0);
`endif

        check("bus queue empty", 32'(exp_a.size()), 32'd0);
        check("data queue empty", 32'(exp_d.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
